// File: rtl/rv32_multicycle_seq.sv
// rtl/rv32_multicycle_seq.sv - multi-cycle instruction sequencer for the RV32I core
//
// Steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP. It drives the
// datapath phase enables and the single shared memory port.
//
// Optional feature macro: RV32_SEQ_PERF_CNT_EN (adds cycle_cnt / instret_cnt)
//
// Ports:
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   run           instruction issue enable, honoured at instruction boundaries
//   opcode        instr[6:0] from the IR, sampled in DECODE
//   branch_taken  ALU branch comparison, used in EXEC
//   mem_ready     memory port completion
//   mem_req       memory request, held until mem_ready
//   mem_we        store qualifier for mem_req
//   mem_addr_sel  0 = PC, 1 = ALU result
//   ir_write      load IR from memory read data
//   reg_write     register file write strobe
//   pc_write      PC update strobe
//   pc_sel        00 = PC+4, 01 = PC-relative target, 10 = JALR target
//   retire        one-cycle pulse per completed instruction
//   illegal_instr high while in TRAP
//   state         current state encoding (debug)
//   cycle_cnt     active-cycle counter (macro only)
//   instret_cnt   retired-instruction counter (macro only)
module rv32_multicycle_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       retire,
  output logic       illegal_instr,
  output logic [2:0] state
`ifdef RV32_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,  // OP, OP-IMM, LUI, AUIPC: all simply write back
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_JAL     = 3'd4,
    C_JALR    = 3'd5,
    C_ILLEGAL = 3'd6
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, dec_cls;
  logic   fin;  // final cycle of the current instruction

  always_comb begin
    case (opcode)
      7'b0110011, 7'b0010011,
      7'b0110111, 7'b0010111: dec_cls = C_ALU;
      7'b0000011:             dec_cls = C_LOAD;
      7'b0100011:             dec_cls = C_STORE;
      7'b1100011:             dec_cls = C_BRANCH;
      7'b1101111:             dec_cls = C_JAL;
      7'b1100111:             dec_cls = C_JALR;
      default:                dec_cls = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ALU;
    end else begin
      state_q <= state_d;
      // The IR opcode is only trusted in DECODE; later states use this copy.
      if (state_q == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    state_d       = state_q;
    fin           = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr_sel  = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 2'b00;
    retire        = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = (dec_cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_LOAD, C_STORE: state_d = S_MEM;
          C_BRANCH: begin
            fin    = 1'b1;
            pc_sel = branch_taken ? 2'b01 : 2'b00;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
        if (mem_ready) begin
          if (cls_q == C_STORE) fin = 1'b1;
          else                  state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        fin       = 1'b1;
        if (cls_q == C_JAL)       pc_sel = 2'b01;
        else if (cls_q == C_JALR) pc_sel = 2'b10;
      end
      S_TRAP: illegal_instr = 1'b1;
      default: state_d = S_IDLE;
    endcase
    // run is honoured only here, so dropping it never aborts an instruction.
    if (fin) begin
      pc_write = 1'b1;
      retire   = 1'b1;
      state_d  = run ? S_FETCH : S_IDLE;
    end
  end

  assign state = state_q;

`ifdef RV32_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state_q != S_IDLE && state_q != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_multicycle_seq.sv
// tb/tb_rv32_multicycle_seq.sv - self-checking bench for rv32_multicycle_seq
module tb_rv32_multicycle_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel, ir_write, reg_write, pc_write;
  logic [1:0] pc_sel;
  logic       retire, illegal_instr;
  logic [2:0] state;
`ifdef RV32_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  rv32_multicycle_seq dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_write(ir_write), .reg_write(reg_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .retire(retire), .illegal_instr(illegal_instr),
    .state(state)
`ifdef RV32_SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, mem_addr_sel, ir_write, reg_write, pc_write, pc_sel, retire, illegal}
  logic [9:0] obs;
  assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, reg_write, pc_write,
                pc_sel, retire, illegal_instr};

  typedef struct {
    logic       r;
    logic [6:0] op;
    logic       bt;
    logic       rdy;
    logic [2:0] st;
    logic [9:0] o;
  } cyc_t;

  cyc_t  sb[$];
  int    tests_run = 0;
  int    failed = 0;
  string cur_test = "";
  int    cyc_idx = 0;

  task automatic push(input logic r, input logic [6:0] op, input logic bt,
                      input logic rdy, input logic [2:0] st, input logic [9:0] o);
    cyc_t c;
    c.r = r; c.op = op; c.bt = bt; c.rdy = rdy; c.st = st; c.o = o;
    sb.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction entered in FETCH. The opcode is
  // presented only in DECODE; afterwards 0 is driven so the latched class matters.
  task automatic push_instr(input logic [6:0] op, input int fw, input int mw,
                            input logic bt, input logic run_tail);
    logic is_ld, is_st, is_br, is_jal, is_jalr;
    is_ld = (op == 7'h03); is_st = (op == 7'h23); is_br = (op == 7'h63);
    is_jal = (op == 7'h6F); is_jalr = (op == 7'h67);
    for (int i = 0; i < fw; i++) push(1'b1, 7'h00, 1'b0, 1'b0, 3'd1, 10'h200);
    push(1'b1, 7'h00, 1'b0, 1'b1, 3'd1, 10'h240);
    push(1'b1, op, 1'b0, 1'b1, 3'd2, 10'h000);
    if (is_br) begin
      push(run_tail, 7'h00, bt, 1'b1, 3'd3, bt ? 10'h016 : 10'h012);
      return;
    end
    push(run_tail, 7'h00, 1'b0, 1'b1, 3'd3, 10'h000);
    if (is_ld || is_st) begin
      for (int i = 0; i < mw; i++)
        push(run_tail, 7'h00, 1'b0, 1'b0, 3'd4, is_st ? 10'h380 : 10'h280);
      push(run_tail, 7'h00, 1'b0, 1'b1, 3'd4, is_st ? 10'h392 : 10'h280);
      if (is_st) return;
    end
    push(run_tail, 7'h00, 1'b0, 1'b1, 3'd5,
         10'h032 | (is_jal ? 10'h004 : 10'h000) | (is_jalr ? 10'h008 : 10'h000));
  endtask

  task automatic push_idle(input logic r);
    push(r, 7'h00, 1'b0, 1'b1, 3'd0, 10'h000);
  endtask

  task automatic run_queue();
    cyc_t c;
    cyc_idx = 0;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      @(posedge clk);
      #1;
      run = c.r; opcode = c.op; branch_taken = c.bt; mem_ready = c.rdy;
      @(negedge clk);
      tests_run++;
      if ({state, obs} !== {c.st, c.o}) begin
        failed++;
        $display("FAIL %s cycle %0d: state/outs got %0d/%03h expected %0d/%03h",
                 cur_test, cyc_idx, state, obs, c.st, c.o);
      end
      cyc_idx++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({state, obs} !== 13'd0) begin
      failed++;
      $display("FAIL %s async reset: state/outs got %0d/%03h expected 0/000",
               cur_test, state, obs);
    end
    run = 1'b0; mem_ready = 1'b0; opcode = 7'd0; branch_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    push_idle(1'b0);
    push_idle(1'b0);
    run_queue();
  endtask

  task automatic test_addi();
    cur_test = "addi";
    push_idle(1'b1);
    push_instr(7'h13, 0, 0, 1'b0, 1'b1);
    push(1'b0, 7'h00, 1'b0, 1'b1, 3'd1, 10'h240);  // next FETCH, no bubble
    run_queue();
    do_reset();
  endtask

  task automatic test_load_waits();
    cur_test = "load_waits";
    push_idle(1'b1);
    push_instr(7'h03, 2, 1, 1'b0, 1'b0);
    push_idle(1'b0);
    run_queue();
  endtask

  task automatic test_branch();
    cur_test = "branch";
    push_idle(1'b1);
    push_instr(7'h63, 0, 0, 1'b1, 1'b1);
    push_instr(7'h63, 1, 0, 1'b0, 1'b0);
    push_idle(1'b0);
    run_queue();
  endtask

  task automatic test_store_jumps();
    cur_test = "store_jumps";
    push_idle(1'b1);
    push_instr(7'h23, 0, 2, 1'b0, 1'b1);
    push_instr(7'h67, 0, 0, 1'b0, 1'b1);
    push_instr(7'h6F, 0, 0, 1'b0, 1'b1);
    push_instr(7'h37, 0, 0, 1'b0, 1'b1);
    push_instr(7'h23, 0, 0, 1'b0, 1'b1);
    push_instr(7'h17, 0, 0, 1'b0, 1'b0);
    push_idle(1'b0);
    run_queue();
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    do_reset();
    push_idle(1'b1);
    push_instr(7'h13, 0, 0, 1'b0, 1'b1);
    push_instr(7'h13, 0, 0, 1'b0, 1'b1);
    push_instr(7'h13, 0, 0, 1'b0, 1'b0);
    push_idle(1'b0);
    run_queue();
`ifdef RV32_SEQ_PERF_CNT_EN
    tests_run++;
    if (instret_cnt !== 32'd3) begin
      failed++;
      $display("FAIL instret_cnt got %0d expected 3", instret_cnt);
    end
    tests_run++;
    if (cycle_cnt !== 32'd12) begin
      failed++;
      $display("FAIL cycle_cnt got %0d expected 12", cycle_cnt);
    end
`endif
  endtask

  task automatic test_run_drop();
    cur_test = "run_drop";
    push_idle(1'b1);
    push_instr(7'h33, 0, 0, 1'b0, 1'b0);
    push_idle(1'b0);
    push_idle(1'b0);
    run_queue();
  endtask

  task automatic test_trap();
    cur_test = "trap";
    push_idle(1'b1);
    push(1'b1, 7'h00, 1'b0, 1'b1, 3'd1, 10'h240);
    push(1'b1, 7'h7F, 1'b0, 1'b1, 3'd2, 10'h000);
    for (int i = 0; i < 20; i++) push(1'b1, 7'h13, 1'b1, 1'b1, 3'd6, 10'h001);
    run_queue();
    do_reset();
    push_idle(1'b0);
    run_queue();
  endtask

  task automatic test_reset_in_fetch();
    cur_test = "reset_in_fetch";
    push_idle(1'b1);
    push(1'b1, 7'h00, 1'b0, 1'b0, 3'd1, 10'h200);
    push(1'b1, 7'h00, 1'b0, 1'b0, 3'd1, 10'h200);
    run_queue();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_req, state} !== 4'd0) begin
      failed++;
      $display("FAIL reset_in_fetch: mem_req/state got %0b/%0d expected 0/0", mem_req, state);
    end
    run = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(1'b0);
    run_queue();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addi();
    test_load_waits();
    test_branch();
    test_store_jumps();
    test_back_to_back();
    test_run_drop();
    test_trap();
    test_reset_in_fetch();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/rv32_multicycle_seq.md
# rv32_multicycle_seq

Multi-cycle sequencer for the RV32I core. Steps each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB/TRAP and drives the per-phase enables of the shared datapath and the single shared memory port. The opcode decoder supplies ALU and operand selects. This block decides when each select is used and when architectural state (PC, IR, register file) is written.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  enables instruction issue; sampled at instruction boundaries
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward
- branch_taken  in  1  branch comparison result from the ALU; valid in EXEC
- mem_ready  in  1  memory port completion for the current request
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write qualifier for mem_req (stores only)
- mem_addr_sel  out  1  0 = PC (instruction), 1 = ALU result (data)
- ir_write  out  1  load the IR from memory read data
- reg_write  out  1  register file write strobe
- pc_write  out  1  PC update strobe
- pc_sel  out  2  00 = PC+4, 01 = PC-relative target (branch/JAL), 10 = JALR target
- retire  out  1  one-cycle pulse per completed instruction
- illegal_instr  out  1  high while in TRAP
- state  out  3  current state encoding, for debug

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_req=1, mem_addr_sel=0, mem_we=0.
  - While mem_ready=0, stay in FETCH.
  - When mem_ready=1, assert ir_write in the same cycle and go to DECODE.
- DECODE: no strobes. Classify opcode:
  - 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 go to EXEC.
  - Any other opcode goes to TRAP.
- EXEC:
  - LOAD and STORE go to MEM.
  - BRANCH is the final cycle. Go to FETCH, or to IDLE if run=0.
  - All others go to WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only. Stay while mem_ready=0.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE completes its final cycle and goes to FETCH, or to IDLE if run=0.
- WB: reg_write=1. Final cycle. Go to FETCH, or to IDLE if run=0.
- Final cycle of every instruction asserts pc_write=1 and retire=1, with pc_sel as follows:
  - 01 for BRANCH when branch_taken=1, and for JAL.
  - 10 for JALR.
  - 00 otherwise, including a not-taken BRANCH.
- TRAP: illegal_instr=1, all strobes 0. Exit only by reset. No retire, no pc_write.
- The opcode class is latched into an internal register in DECODE. Later states use the latched class, not the live opcode.

## Timing
- Reset (rst_n=0): state=IDLE. All outputs 0 immediately, independent of clk.
- After rst_n deasserts, the first possible FETCH is the cycle after the first edge that samples run=1.
- Latency with zero-wait memory (mem_ready=1 in the first cycle of each request):
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle (mem_ready=0) adds exactly one cycle.
- Handshake:
  - mem_req, mem_we and mem_addr_sel stay constant from request assertion until the cycle where mem_ready=1.
  - mem_req drops in the following cycle.
  - mem_ready arriving while mem_req=0 is ignored.
- Strobe outputs are combinational from state, latched class, branch_taken and mem_ready. They are Mealy on mem_ready only for ir_write and for the STORE final-cycle signals.
- Back-to-back instructions: the cycle after a final cycle is FETCH when run=1. There are no idle bubbles.
- run=0 mid-instruction does not abort the instruction. It is honoured only at the final cycle.
- An asynchronous reset during MEM or FETCH drops mem_req in the same cycle. No partial write is signalled.

## Configuration
- RV32_SEQ_PERF_CNT_EN defined: adds two 32-bit outputs.
  - cycle_cnt increments on every clock while state≠IDLE and state≠TRAP.
  - instret_cnt increments on every retire.
  - Both reset to 0 and wrap from 0xFFFFFFFF to 0.
- RV32_SEQ_PERF_CNT_EN undefined: no counter ports and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then run=1, fetch 0x00500093 (ADDI) with zero-wait memory -> states 1,2,3,5,1. reg_write=1 and retire=1 in cycle 4. pc_sel=00.
- LOAD 0x0000A103 with 2 wait cycles in FETCH and 1 in MEM -> mem_req held with address select stable; ir_write only on the ready cycle; reg_write 8 cycles after the FETCH start.
- BRANCH 0x00208463 with branch_taken=1 -> pc_write with pc_sel=01 in EXEC, no reg_write. Repeat with branch_taken=0 -> pc_sel=00.
- STORE 0x0020A023 -> mem_we=1 only in MEM. Final cycle coincides with mem_ready. JALR 0x000080E7 -> WB with pc_sel=10.
- Opcode 0x7F -> TRAP after DECODE, illegal_instr=1 and no retire for 20 cycles. rst_n pulse -> IDLE with all outputs 0.
- run dropped during EXEC of ADD 0x002081B3 -> instruction completes, then IDLE. With the macro defined, after 3 retired ADDI: instret_cnt=3 and cycle_cnt=12.
